// File: rtl/counter_rr_pkg.sv
// Shared constants and arbitration helpers for the round-robin counter scheduler.
package counter_rr_pkg;
  localparam int unsigned N_CNT_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned PEND_W_DEF = 2;

  localparam int unsigned N_MAX = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_MAX-1:0] vec_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  typedef enum logic {
    BURST_OFF,
    BURST_SECOND
  } burst_e;

  // First eligible index after ptr, wrapping modulo n (n <= N_MAX).
  function automatic pick_t rr_pick(input vec_t eligible, input idx_t ptr, input int unsigned n);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned k = 1; k <= N_MAX; k++) begin
      if (k <= n) begin
        cand = (32'(ptr) + k) % n;
        if (!p.valid && eligible[idx_t'(cand)]) begin
          p.valid = 1'b1;
          p.idx   = idx_t'(cand);
        end
      end
    end
    return p;
  endfunction

  function automatic vec_t onehot(input idx_t idx);
    vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/counter_rr_sched_if.sv
// Request/grant/status bundle between a tick source and counter_rr_sched.
interface counter_rr_sched_if #(
  parameter int unsigned N_CNT = counter_rr_pkg::N_CNT_DEF
);
  logic [N_CNT-1:0] req;
  logic [N_CNT-1:0] grant;
  logic [N_CNT-1:0] drop;
  logic [N_CNT-1:0] led;
  logic             busy;

  modport master (output req, input grant, busy, drop, led);
  modport slave  (input req, output grant, busy, drop, led);
endinterface

// File: rtl/counter_rr_sched_arbiter.sv
// rr_arbiter: purely combinational round-robin pick over an eligible vector.
module rr_arbiter
  import counter_rr_pkg::*;
#(
  parameter int unsigned N_CNT = N_CNT_DEF
) (
  input  logic [N_CNT-1:0] eligible,
  input  idx_t             ptr,
  output idx_t             win,
  output logic             valid
);
  vec_t  elig_ext;
  pick_t pick;

  always_comb begin
    elig_ext              = '0;
    elig_ext[N_CNT-1:0]   = eligible;
    pick                  = rr_pick(elig_ext, ptr, N_CNT);
    win                   = pick.idx;
    valid                 = pick.valid;
  end
endmodule

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one incrementer among N_CNT counters.
// Optional COUNTER_RR_SCHED_WEIGHT_EN adds weight_sel for double-grant bursts.
module counter_rr_sched
  import counter_rr_pkg::*;
#(
  parameter int unsigned N_CNT  = N_CNT_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
  input  logic [N_CNT-1:0] weight_sel,
`endif
  counter_rr_sched_if.slave bus
);
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [CNT_W-1:0]  cnt      [N_CNT];
  logic [PEND_W-1:0] pend     [N_CNT];
  logic [PEND_W-1:0] pend_nxt [N_CNT];
  logic [N_CNT-1:0]  eligible, gnt_nxt, drop_set, grant_q, drop_q;
  logic              busy_q, busy_nxt;
  logic              arb_valid, win_valid;
  idx_t              ptr, ptr_nxt, arb_win, win;
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
  burst_e            burst, burst_nxt;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_CNT; i++) eligible[i] = (pend[i] != '0);
  end

  rr_arbiter #(.N_CNT(N_CNT)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .win      (arb_win),
    .valid    (arb_valid)
  );

  always_comb begin
    win       = arb_win;
    win_valid = arb_valid;
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
    // ptr already points at the burst channel, so the second grant re-picks it.
    burst_nxt = BURST_OFF;
    if (burst == BURST_SECOND) begin
      win       = ptr;
      win_valid = 1'b1;
    end
`endif
    gnt_nxt = win_valid ? N_CNT'(onehot(win)) : '0;
    ptr_nxt = win_valid ? win : ptr;
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
    if (burst == BURST_OFF) begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        if (gnt_nxt[i] && weight_sel[i] && (pend[i] > PEND_W'(1))) burst_nxt = BURST_SECOND;
      end
    end
`endif
    drop_set = '0;
    busy_nxt = 1'b0;
    for (int unsigned i = 0; i < N_CNT; i++) begin
      pend_nxt[i] = pend[i];
      if (bus.req[i] && !gnt_nxt[i]) begin
        if (pend[i] == PMAX) drop_set[i] = 1'b1;
        else                 pend_nxt[i] = pend[i] + 1'b1;
      end else if (!bus.req[i] && gnt_nxt[i]) begin
        pend_nxt[i] = pend[i] - 1'b1;
      end
      if (pend_nxt[i] != '0) busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        cnt[i]  <= '0;
        pend[i] <= '0;
      end
      drop_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr     <= idx_t'(N_CNT - 1);
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
      burst   <= BURST_OFF;
`endif
    end else begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        pend[i] <= pend_nxt[i];
        if (gnt_nxt[i]) cnt[i] <= cnt[i] + 1'b1;
      end
      drop_q  <= drop_q | drop_set;
      grant_q <= gnt_nxt;
      busy_q  <= busy_nxt;
      ptr     <= ptr_nxt;
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
      burst   <= burst_nxt;
`endif
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CNT; i++) bus.led[i] = cnt[i][CNT_W-1];
  end

  assign bus.grant = grant_q;
  assign bus.drop  = drop_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_counter_rr_sched.sv
// Randomized and directed bench for counter_rr_sched against an integer reference model.
module tb_counter_rr_sched;
  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int PMAX = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] wsel = '0;

  always #5 clk = ~clk;

  counter_rr_sched_if #(.N_CNT(N)) bus ();

  counter_rr_sched #(.N_CNT(N), .CNT_W(CW), .PEND_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef COUNTER_RR_SCHED_WEIGHT_EN
    .weight_sel (wsel),
`endif
    .bus        (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference state kept as plain integers.
  int       m_cnt  [N];
  int       m_pend [N];
  int       m_ptr;
  int       m_last;
  bit       m_burst;
  bit [N-1:0] m_drop, m_grant;
  bit       m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input bit do_rst);
    int win;
    if (do_rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i]  = 0;
        m_pend[i] = 0;
      end
      m_ptr = N - 1; m_burst = 0; m_last = 0;
      m_drop = '0; m_grant = '0; m_busy = 0;
      return;
    end
    win = -1;
    if (m_burst) begin
      win     = m_last;
      m_burst = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && m_pend[c] > 0) win = c;
      end
      if (win >= 0 && wsel[win] && m_pend[win] >= 2) begin
        m_burst = 1;
        m_last  = win;
      end
    end
    if (win >= 0) m_ptr = win;
    m_busy = 0;
    for (int i = 0; i < N; i++) begin
      int g;
      g = (win == i) ? 1 : 0;
      m_grant[i] = (g == 1);
      if (r[i] && g == 0 && m_pend[i] == PMAX) m_drop[i] = 1'b1;
      m_pend[i] = m_pend[i] + int'(r[i]) - g;
      if (m_pend[i] > PMAX) m_pend[i] = PMAX;
      m_cnt[i] = (m_cnt[i] + g) % (1 << CW);
      if (m_pend[i] > 0) m_busy = 1;
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input bit do_rst = 1'b0);
    bit [N-1:0] eled;
    @(negedge clk);
    bus.req = r;
    rst     = do_rst;
    model_edge(r, do_rst);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) eled[i] = (m_cnt[i] >= (1 << (CW - 1)));
    check("grant", 32'(bus.grant), 32'(m_grant));
    check("busy",  32'(bus.busy),  32'(m_busy));
    check("drop",  32'(bus.drop),  32'(m_drop));
    check("led",   32'(bus.led),   32'(eled));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b1);
  endtask

  initial begin
    int ng;
    logic [N-1:0] gseq [12];
    logic [N-1:0] fair_exp [4];
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010;
    fair_exp[2] = 4'b0100; fair_exp[3] = 4'b1000;
    bus.req = '0;

    // Reset then single tick
    do_reset(2);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy",  32'(bus.busy),  0);
    check("rst_drop",  32'(bus.drop),  0);
    check("rst_led",   32'(bus.led),   0);
    cycle(4'b0001);
    check("tick_busy", 32'(bus.busy), 1);
    cycle(4'b0000);
    check("tick_grant", 32'(bus.grant), 32'(4'b0001));
    check("tick_idle",  32'(bus.busy),  0);
    cycle(4'b0000);

    // Fairness from a fresh reset
    do_reset(1);
    cycle(4'b1111);
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0000);
      check("fair_order", 32'(bus.grant), 32'(fair_exp[k]));
    end
    check("fair_busy_end", 32'(bus.busy), 0);

    // Wrap on channel 2
    do_reset(1);
    for (int t = 1; t <= 256; t++) begin
      cycle(4'b0100);
      cycle(4'b0000);
      if (t == 127) check("led2_127", 32'(bus.led[2]), 0);
      if (t == 128) check("led2_128", 32'(bus.led[2]), 1);
      if (t == 255) check("led2_255", 32'(bus.led[2]), 1);
      if (t == 256) check("led2_wrap", 32'(bus.led[2]), 0);
    end
    check("wrap_nodrop", 32'(bus.drop), 0);

    // Saturation and drain
    do_reset(1);
    for (int k = 0; k < 20; k++) cycle(4'b1111);
    check("sat_drop", 32'(bus.drop), 32'(4'b1111));
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0000);
      ng += $countones(bus.grant);
    end
    check("drain_grants", 32'(ng), 12);
    check("drain_idle", 32'(bus.busy), 0);

    // Same-cycle request and grant on one channel
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      cycle(4'b0010);
      if (k >= 1) check("hold_grant", 32'(bus.grant), 32'(4'b0010));
    end
    check("hold_nodrop", 32'(bus.drop), 0);

    // Reset while ticks are pending
    do_reset(1);
    for (int k = 0; k < 3; k++) cycle(4'b1111);
    check("mid_busy", 32'(bus.busy), 1);
    cycle(4'b1111, 1'b1);
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_busy",  32'(bus.busy),  0);
    check("mid_rst_drop",  32'(bus.drop),  0);
    cycle(4'b1111);
    cycle(4'b0000);
    check("mid_first_ch0", 32'(bus.grant), 32'(4'b0001));

    // Random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      cycle(r, ($urandom_range(0, 49) == 0));
    end

`ifdef COUNTER_RR_SCHED_WEIGHT_EN
    do_reset(1);
    wsel = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      cycle(4'b0011);
      gseq[k] = bus.grant;
    end
    for (int k = 3; k < 9; k++)
      check("weight_pat", 32'(gseq[k]), ((k % 3) == 2) ? 32'(4'b0010) : 32'(4'b0001));
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 19) == 0) wsel = N'($urandom);
      cycle(r, ($urandom_range(0, 59) == 0));
    end
    wsel = '0;
`else
    gseq[0] = '0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
